// File: rtl/axi_slave_ram.sv
// AXI4 INCR-burst slave backed by an on-chip register-array RAM, independent write and read channels.
// Optional: define AXI_RAM_BACKPRESSURE_EN to throttle wready and read beat issue with a 16-bit LFSR.
module axi_slave_ram #(
    parameter int AXI_WIDTH   = 64,
    parameter int AXI_WSTRB_W = AXI_WIDTH >> 3,
    parameter int AXI_AXSIZE  = 3,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_ADDR_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             s_axi_awid,
    input  logic [29:0]            s_axi_awaddr,
    input  logic [7:0]             s_axi_awlen,
    input  logic [2:0]             s_axi_awsize,
    input  logic [1:0]             s_axi_awburst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [AXI_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_WSTRB_W-1:0] s_axi_wstrb,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [3:0]             s_axi_bid,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [3:0]             s_axi_arid,
    input  logic [29:0]            s_axi_araddr,
    input  logic [7:0]             s_axi_arlen,
    input  logic [2:0]             s_axi_arsize,
    input  logic [1:0]             s_axi_arburst,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [3:0]             s_axi_rid,
    output logic [AXI_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   protocol_err
);

    localparam logic [2:0] SIZE_OK     = 3'(AXI_AXSIZE);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [AXI_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [3:0]            w_id_q, w_id_d;
    logic [MEM_ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic [3:0]            bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  perr_q, perr_d;

    r_state_e              r_state_q, r_state_d;
    logic [3:0]            rid_q, rid_d;
    logic [MEM_ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [AXI_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;

    logic                  w_gate, r_gate;
    logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                  aw_bad, ar_bad, w_last_beat;
    logic                  load_en;
    logic [MEM_ADDR_W-1:0] load_idx;
    logic [7:0]            load_cnt, load_len;
    logic                  unused_addr_bits;

`ifdef AXI_RAM_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign w_gate = lfsr_q[0];
    assign r_gate = lfsr_q[1];
`else
    assign w_gate = 1'b1;
    assign r_gate = 1'b1;
`endif

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA) && w_gate;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign protocol_err  = perr_q;

    assign aw_fire     = s_axi_awvalid && s_axi_awready;
    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign b_fire      = s_axi_bvalid && s_axi_bready;
    assign ar_fire     = s_axi_arvalid && s_axi_arready;
    assign r_fire      = rvalid_q && s_axi_rready;
    assign aw_bad      = (s_axi_awburst != BURST_INCR) || (s_axi_awsize != SIZE_OK);
    assign ar_bad      = (s_axi_arburst != BURST_INCR) || (s_axi_arsize != SIZE_OK);
    assign w_last_beat = (w_cnt_q == w_len_q);

    // Only the word-index bits of the byte addresses select RAM words.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        perr_d    = perr_q | (aw_fire && aw_bad) | (ar_fire && ar_bad)
                           | (w_fire && (s_axi_wlast != w_last_beat));

        unique case (w_state_q)
            W_IDLE: if (aw_fire) begin
                w_id_d    = s_axi_awid;
                w_idx_d   = s_axi_awaddr[AXI_AXSIZE +: MEM_ADDR_W];
                w_len_d   = s_axi_awlen;
                w_cnt_d   = 8'd0;
                w_err_d   = aw_bad;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_fire) begin
                if (w_last_beat) begin
                    w_state_d = W_RESP;
                    bid_d     = w_id_q;
                    bresp_d   = w_err_q ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    w_idx_d = w_idx_q + MEM_ADDR_W'(1);
                end
            end
            W_RESP: if (b_fire) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read side: one load path shared by the first beat and every following beat.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_ptr_d   = r_ptr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        load_en   = 1'b0;
        load_idx  = r_ptr_q;
        load_cnt  = r_cnt_q;
        load_len  = r_len_q;

        case (r_state_q)
            R_IDLE: if (ar_fire) begin
                rid_d     = s_axi_arid;
                rresp_d   = ar_bad ? RESP_SLVERR : RESP_OKAY;
                r_len_d   = s_axi_arlen;
                r_ptr_d   = s_axi_araddr[AXI_AXSIZE +: MEM_ADDR_W];
                r_cnt_d   = 8'd0;
                load_idx  = s_axi_araddr[AXI_AXSIZE +: MEM_ADDR_W];
                load_cnt  = 8'd0;
                load_len  = s_axi_arlen;
                load_en   = r_gate;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_fire) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        load_en = r_gate;
                    end
                end else if (!rvalid_q) begin
                    load_en = r_gate;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // The RAM is read before this edge's write lands, so a same-word collision returns old data.
        if (load_en) begin
            rdata_d  = mem[load_idx];
            rvalid_d = 1'b1;
            rlast_d  = (load_cnt == load_len);
            r_ptr_d  = load_idx + MEM_ADDR_W'(1);
            r_cnt_d  = load_cnt + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            perr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_ptr_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            perr_q    <= perr_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            r_ptr_q   <= r_ptr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would turn it into a huge flop bank.
    always_ff @(posedge clk) begin
        if (w_fire && !w_err_q) begin
            for (int b = 0; b < AXI_WSTRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule
